// File: rtl/local_mem_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : local_mem_bank_pkg                                               |
// | Purpose : Shared definitions for the local scratch memory bank: FSM state  |
// |           encoding, byte-lane width and a parameter legality helper.       |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package local_mem_bank_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/host_byte_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : host_byte_lane                                                   |
// | Purpose : Combinational byte access into one memory row: selects the byte  |
// |           at a given offset for reads and builds the row with that byte    |
// |           replaced for writes. Byte k occupies bits [8k+7:8k].             |
// | Ports   : row_data   in  current row contents                              |
// |           offset     in  byte offset within the row                        |
// |           wr_byte    in  byte to merge                                     |
// |           rd_byte    out selected byte                                     |
// |           merged_row out row with wr_byte inserted at offset               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module host_byte_lane
  import local_mem_bank_pkg::*;
#(
  parameter int CHUNK_BITS = 512,
  parameter int OFF_W      = 6
) (
  input  logic [CHUNK_BITS-1:0] row_data,
  input  logic [OFF_W-1:0]      offset,
  input  logic [LANE_W-1:0]     wr_byte,
  output logic [LANE_W-1:0]     rd_byte,
  output logic [CHUNK_BITS-1:0] merged_row
);

  // Bit position of the selected byte; the shift by 3 is the *8 lane scaling.
  logic [OFF_W+2:0] bit_base;
  assign bit_base = {offset, 3'b000};

  assign rd_byte = row_data[bit_base +: LANE_W];

  always_comb begin
    merged_row = row_data;
    merged_row[bit_base +: LANE_W] = wr_byte;
  end

endmodule
`default_nettype wire

// File: rtl/local_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : local_mem_bank                                                   |
// | Purpose : Multi-row scratch memory for the matrix unit. A wide chunk port  |
// |           moves whole rows, a host port accesses single bytes. Reset or a  |
// |           soft clear zero-fills the array one row per cycle before any     |
// |           request is accepted. Both read ports have 1-cycle latency.       |
// | Ports   : clk, rst (async active-low), clear, ready                        |
// |           chunk_wr_en/row/data, chunk_rd_en/row, chunk_rd_data/valid       |
// |           host_wr_en, host_rd_en, host_addr, host_wr_data,                 |
// |           host_rd_data/valid, host_err                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module local_mem_bank
  import local_mem_bank_pkg::*;
#(
  parameter  int CHUNK_BITS = 512,
  parameter  int DEPTH      = 8,
  localparam int BYTES      = CHUNK_BITS / 8,
  localparam int ROW_W      = $clog2(DEPTH),
  localparam int OFF_W      = $clog2(BYTES),
  localparam int ADDR_W     = ROW_W + OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  chunk_wr_en,
  input  logic [ROW_W-1:0]      chunk_wr_row,
  input  logic [CHUNK_BITS-1:0] chunk_wr_data,
  input  logic                  chunk_rd_en,
  input  logic [ROW_W-1:0]      chunk_rd_row,
  output logic [CHUNK_BITS-1:0] chunk_rd_data,
  output logic                  chunk_rd_valid,
  input  logic                  host_wr_en,
  input  logic                  host_rd_en,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [7:0]            host_wr_data,
  output logic [7:0]            host_rd_data,
  output logic                  host_rd_valid,
  output logic                  host_err
);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2 || (CHUNK_BITS % LANE_W) != 0 || CHUNK_BITS < 16) begin : g_param_check
      $error("local_mem_bank: DEPTH must be a power of 2 >= 2, CHUNK_BITS a multiple of 8 >= 16");
    end
  endgenerate

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH - 1);

  state_t            state;
  logic [ROW_W-1:0]  sweep_row;

  // Storage is never reset; the sweep is the only zeroing mechanism.
  logic [CHUNK_BITS-1:0] mem [DEPTH-1:0];

  logic [ROW_W-1:0]      host_row;
  logic [OFF_W-1:0]      host_off;
  logic [7:0]            lane_rd_byte;
  logic [CHUNK_BITS-1:0] lane_merged_row;

  assign host_row = host_addr[ADDR_W-1:OFF_W];
  assign host_off = host_addr[OFF_W-1:0];

  host_byte_lane #(
    .CHUNK_BITS (CHUNK_BITS),
    .OFF_W      (OFF_W)
  ) u_lane (
    .row_data   (mem[host_row]),
    .offset     (host_off),
    .wr_byte    (host_wr_data),
    .rd_byte    (lane_rd_byte),
    .merged_row (lane_merged_row)
  );

  // A clear in RUN wins over any write issued in the same cycle.
  logic wr_ok;
  logic host_collide;
  logic do_chunk_wr;
  logic do_host_wr;
  logic do_chunk_rd;
  logic do_host_rd;
  logic host_err_next;

  assign wr_ok         = ready && !clear;
  assign host_collide  = chunk_wr_en && host_wr_en && (chunk_wr_row == host_row);
  assign do_chunk_wr   = wr_ok && chunk_wr_en;
  assign do_host_wr    = wr_ok && host_wr_en && !host_collide;
  assign do_chunk_rd   = ready && chunk_rd_en;
  assign do_host_rd    = ready && host_rd_en && !host_wr_en;
  assign host_err_next = (!ready && (host_wr_en || host_rd_en)) ||
                         (ready && host_wr_en && (host_rd_en || host_collide));

  // Control FSM; ready is registered and tracks state == ST_RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_CLR;
      sweep_row <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          if (sweep_row == LAST_ROW) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            sweep_row <= sweep_row + 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            state     <= ST_CLR;
            sweep_row <= '0;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= ST_CLR;
          sweep_row <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Array writes. Same-row chunk/host collisions are excluded by do_host_wr.
  always_ff @(posedge clk) begin
    if (state == ST_CLR) begin
      mem[sweep_row] <= '0;
    end else begin
      if (do_chunk_wr) mem[chunk_wr_row] <= chunk_wr_data;
      if (do_host_wr)  mem[host_row]     <= lane_merged_row;
    end
  end

  // Read-first registered read ports; data holds between accepted reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunk_rd_data  <= '0;
      chunk_rd_valid <= 1'b0;
      host_rd_data   <= '0;
      host_rd_valid  <= 1'b0;
      host_err       <= 1'b0;
    end else begin
      chunk_rd_valid <= do_chunk_rd;
      if (do_chunk_rd) chunk_rd_data <= mem[chunk_rd_row];
      host_rd_valid <= do_host_rd;
      if (do_host_rd) host_rd_data <= lane_rd_byte;
      host_err <= host_err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_local_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_local_mem_bank                                                |
// | Purpose : Directed self-checking bench for local_mem_bank (512b x 8 rows). |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_local_mem_bank;

  localparam int CB    = 512;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          ready;
  logic          chunk_wr_en = 1'b0;
  logic [2:0]    chunk_wr_row = '0;
  logic [CB-1:0] chunk_wr_data = '0;
  logic          chunk_rd_en = 1'b0;
  logic [2:0]    chunk_rd_row = '0;
  logic [CB-1:0] chunk_rd_data;
  logic          chunk_rd_valid;
  logic          host_wr_en = 1'b0;
  logic          host_rd_en = 1'b0;
  logic [8:0]    host_addr = '0;
  logic [7:0]    host_wr_data = '0;
  logic [7:0]    host_rd_data;
  logic          host_rd_valid;
  logic          host_err;

  int n_cmp = 0;
  int n_bad = 0;

  local_mem_bank #(.CHUNK_BITS(CB), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .ready          (ready),
    .chunk_wr_en    (chunk_wr_en),
    .chunk_wr_row   (chunk_wr_row),
    .chunk_wr_data  (chunk_wr_data),
    .chunk_rd_en    (chunk_rd_en),
    .chunk_rd_row   (chunk_rd_row),
    .chunk_rd_data  (chunk_rd_data),
    .chunk_rd_valid (chunk_rd_valid),
    .host_wr_en     (host_wr_en),
    .host_rd_en     (host_rd_en),
    .host_addr      (host_addr),
    .host_wr_data   (host_wr_data),
    .host_rd_data   (host_rd_data),
    .host_rd_valid  (host_rd_valid),
    .host_err       (host_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; chunk_wr_en = 1'b0; chunk_rd_en = 1'b0;
    host_wr_en = 1'b0; host_rd_en = 1'b0;
  endtask

  task automatic chunk_write(input logic [2:0] row, input logic [CB-1:0] data);
    idle();
    chunk_wr_en = 1'b1; chunk_wr_row = row; chunk_wr_data = data;
    tick();
    idle();
  endtask

  task automatic chunk_read_check(input string tag, input logic [2:0] row, input logic [CB-1:0] exp);
    idle();
    chunk_rd_en = 1'b1; chunk_rd_row = row;
    tick();
    idle();
    check({tag, "_valid"}, CB'(chunk_rd_valid), CB'(1));
    check(tag, chunk_rd_data, exp);
  endtask

  task automatic host_read_check(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    idle();
    host_rd_en = 1'b1; host_addr = addr;
    tick();
    idle();
    check({tag, "_valid"}, CB'(host_rd_valid), CB'(1));
    check(tag, CB'(host_rd_data), CB'(exp));
  endtask

  // After a reset release or clear edge: ready low for DEPTH cycles, then high.
  task automatic check_sweep(input string tag, input int already);
    for (int i = already; i < DEPTH; i++) begin
      tick();
      check({tag, "_ready_low"}, CB'(ready), CB'(0));
    end
    tick();
    check({tag, "_ready_high"}, CB'(ready), CB'(1));
  endtask

  logic [CB-1:0] pat;
  logic [CB-1:0] ones;
  logic [CB-1:0] data_a;
  logic [CB-1:0] data_b;

  initial begin
    for (int k = 0; k < 64; k++) pat[8*k +: 8] = 8'(64 - k);
    ones   = '1;
    data_a = {16{32'hDEADBEEF}};
    data_b = {16{32'h12345678}};

    // 1: reset state, sweep length, all rows zero
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", CB'(ready), CB'(0));
    check("rst_crd_valid", CB'(chunk_rd_valid), CB'(0));
    check("rst_hrd_valid", CB'(host_rd_valid), CB'(0));
    check("rst_herr", CB'(host_err), CB'(0));
    check("rst_crd_data", chunk_rd_data, '0);
    @(negedge clk);
    rst = 1'b1;
    // first post-release edge is the first sweep cycle
    check_sweep("init", 1);
    for (int r = 0; r < DEPTH; r++) chunk_read_check("init_row0", 3'(r), '0);

    // 2: chunk write, host byte reads
    chunk_write(3'd3, pat);
    host_read_check("t2_byte0", 9'(3*64 + 0), 8'h40);
    host_read_check("t2_byte63", 9'(3*64 + 63), 8'h01);

    // 3: host byte write, chunk read
    idle();
    host_wr_en = 1'b1; host_addr = 9'(5*64 + 2); host_wr_data = 8'hA5;
    tick();
    idle();
    chunk_read_check("t3_row5", 3'd5, CB'(24'hA50000));

    // 4: same-row collision, chunk wins
    idle();
    chunk_wr_en = 1'b1; chunk_wr_row = 3'd2; chunk_wr_data = ones;
    host_wr_en = 1'b1; host_addr = 9'(2*64); host_wr_data = 8'h00;
    tick();
    idle();
    check("t4_err_same", CB'(host_err), CB'(1));
    tick();
    check("t4_err_one_cycle", CB'(host_err), CB'(0));
    chunk_read_check("t4_row2", 3'd2, ones);
    // different rows: both land
    chunk_wr_en = 1'b1; chunk_wr_row = 3'd2; chunk_wr_data = ones;
    host_wr_en = 1'b1; host_addr = 9'(4*64); host_wr_data = 8'h5A;
    tick();
    idle();
    check("t4_err_diff", CB'(host_err), CB'(0));
    chunk_read_check("t4_row4", 3'd4, CB'(8'h5A));
    chunk_read_check("t4_row2b", 3'd2, ones);

    // 5: host read+write same cycle
    host_wr_en = 1'b1; host_rd_en = 1'b1; host_addr = 9'(6*64 + 1); host_wr_data = 8'h3C;
    tick();
    idle();
    check("t5_err", CB'(host_err), CB'(1));
    check("t5_no_valid", CB'(host_rd_valid), CB'(0));
    host_read_check("t5_byte", 9'(6*64 + 1), 8'h3C);
    // chunk read-first
    chunk_write(3'd1, data_a);
    chunk_rd_en = 1'b1; chunk_rd_row = 3'd1;
    chunk_wr_en = 1'b1; chunk_wr_row = 3'd1; chunk_wr_data = data_b;
    tick();
    idle();
    check("t5_rd_first_valid", CB'(chunk_rd_valid), CB'(1));
    check("t5_rd_first", chunk_rd_data, data_a);
    chunk_read_check("t5_new", 3'd1, data_b);

    // 6: fill, clear (with a read and a dropped write in the clear cycle)
    for (int r = 0; r < DEPTH; r++) chunk_write(3'(r), {64{8'(r + 1)}});
    clear = 1'b1;
    chunk_rd_en = 1'b1; chunk_rd_row = 3'd7;
    host_wr_en = 1'b1; host_addr = 9'(7*64); host_wr_data = 8'hEE;
    tick();
    idle();
    check("t6_clr_ready", CB'(ready), CB'(0));
    check("t6_clr_rd", chunk_rd_data, {64{8'h08}});
    // request during sweep: dropped, host_err pulses
    host_rd_en = 1'b1; host_addr = 9'd0;
    chunk_rd_en = 1'b1; chunk_rd_row = 3'd0;
    tick();
    idle();
    check("t6_sweep_herr", CB'(host_err), CB'(1));
    check("t6_sweep_hvalid", CB'(host_rd_valid), CB'(0));
    check("t6_sweep_cvalid", CB'(chunk_rd_valid), CB'(0));
    check_sweep("clr", 2);
    for (int r = 0; r < DEPTH; r++) chunk_read_check("clr_row0", 3'(r), '0);

    // reset mid-sweep: clear with a read in flight, then assert rst
    chunk_write(3'd0, ones);
    clear = 1'b1;
    chunk_rd_en = 1'b1; chunk_rd_row = 3'd0;
    tick();
    idle();
    check("t6_pre_rst_valid", CB'(chunk_rd_valid), CB'(1));
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_cvalid", CB'(chunk_rd_valid), CB'(0));
    check("t6_rst_ready", CB'(ready), CB'(0));
    check("t6_rst_data", chunk_rd_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_sweep("rst2", 1);
    check("t6_post_hvalid", CB'(host_rd_valid), CB'(0));
    chunk_read_check("rst2_row0", 3'd0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
